// File: rtl/frame_writer.sv
// Writer side of the SDRAM frame-buffer handshake: captures one frame of pixels
// into a small first-word-fall-through FIFO and streams them to the sequential
// SDRAM write port while the display side yields access.
module frame_writer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       pix_valid,
    input  logic       pix_sof,
    input  logic [7:0] pix_data,
    input  logic       yield,
    input  logic       write_ready,
    output logic       write_enable,
    output logic [7:0] write_data,
    output logic       write_complete,
    output logic       overflow,
    output logic       frame_err
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            frame_err_q, frame_err_d;
    logic            write_complete_q, write_complete_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_req;
    logic            push;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == NW'(FIFO_DEPTH));

    // Drain path: FIFO head goes straight to the SDRAM port whenever it can be taken.
    always_comb begin
        pop          = (state_q == S_FILL || state_q == S_DRAIN) && yield && write_ready && !fifo_empty;
        write_enable = pop;
        write_data   = pop ? mem_q[rd_ptr_q] : '0;
    end

    // Frame sequencing, pixel counting, FIFO bookkeeping and sticky error flags.
    always_comb begin
        state_d          = state_q;
        in_cnt_d         = in_cnt_q;
        overflow_d       = overflow_q;
        frame_err_d      = frame_err_q;
        push_req         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pix_valid && pix_sof) begin
                    push_req = 1'b1;
                    in_cnt_d = CW'(1);
                    state_d  = (NPIX == 1) ? S_DRAIN : S_FILL;
                end
            end
            S_FILL: begin
                if (pix_valid) begin
                    push_req = 1'b1;
                    if (pix_sof) frame_err_d = 1'b1;
                    in_cnt_d = in_cnt_q + CW'(1);
                    if (in_cnt_q == CW'(NPIX - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) state_d = S_DONE;
            end
            S_DONE: begin
                if (!yield) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (yield) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A full FIFO still accepts a push when the head leaves in the same cycle;
        // a rejected pixel is counted anyway so the frame geometry is preserved.
        push = push_req && (!fifo_full || pop);
        if (push_req && !push) overflow_d = 1'b1;

        wr_ptr_d         = wr_ptr_q + AW'(push);
        rd_ptr_d         = rd_ptr_q + AW'(pop);
        count_d          = count_q + NW'(push) - NW'(pop);
        write_complete_d = (state_d == S_DONE);
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            in_cnt_q         <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            frame_err_q      <= 1'b0;
            write_complete_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            in_cnt_q         <= in_cnt_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            frame_err_q      <= frame_err_d;
            write_complete_q <= write_complete_d;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy count says empty.
    always_ff @(posedge CLOCK_50) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= pix_data;
    end

    assign write_complete = write_complete_q;
    assign overflow       = overflow_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: fixed vector table for the first frame, directed
// corner-case sequences, then randomized traffic against a queue-based model.
module tb_frame_writer;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 4;
    localparam int NPIX  = W * H;

    logic       clk = 1'b0;
    logic       rst_n, pix_valid, pix_sof, yield, write_ready;
    logic [7:0] pix_data;
    logic       write_enable, write_complete, overflow, frame_err;
    logic [7:0] write_data;

    always #5 clk = ~clk;

    frame_writer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50      (clk),
        .rst_n         (rst_n),
        .pix_valid     (pix_valid),
        .pix_sof       (pix_sof),
        .pix_data      (pix_data),
        .yield         (yield),
        .write_ready   (write_ready),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .write_complete(write_complete),
        .overflow      (overflow),
        .frame_err     (frame_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit en_chk = 1'b0;

    // Behavioural model: frame phase, a queue standing in for the FIFO, counters.
    typedef enum {P_IDLE, P_FILL, P_DRAIN, P_DONE, P_RELEASE} phase_t;
    phase_t     m_ph = P_IDLE;
    logic [7:0] m_q[$];
    int         m_cnt = 0;
    bit         m_wc = 0, m_ovf = 0, m_ferr = 0;

    logic [7:0] wr_log[$];

    typedef struct {
        bit rn; bit v; bit s; logic [7:0] d; bit y; bit r;
        bit e_we; logic [7:0] e_wd; bit e_wc; bit e_ovf; bit e_ferr;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit rn, bit v, bit s, logic [7:0] d, bit y, bit r,
                                bit e_we, logic [7:0] e_wd, bit e_wc, bit e_ovf, bit e_ferr);
        vec_t t;
        t.rn = rn; t.v = v; t.s = s; t.d = d; t.y = y; t.r = r;
        t.e_we = e_we; t.e_wd = e_wd; t.e_wc = e_wc; t.e_ovf = e_ovf; t.e_ferr = e_ferr;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model across the coming rising edge.
    task automatic step(input bit rn, input bit v, input bit s, input logic [7:0] d,
                        input bit y, input bit r);
        bit         e_we;
        logic [7:0] e_wd;
        @(negedge clk);
        rst_n = rn; pix_valid = v; pix_sof = s; pix_data = d; yield = y; write_ready = r;
        #1;
        e_we = (m_ph == P_FILL || m_ph == P_DRAIN) && y && r && (m_q.size() > 0);
        e_wd = e_we ? m_q[0] : 8'h00;
        if (en_chk) begin
            chk("write_enable", write_enable, e_we);
            chk("write_data", write_data, e_wd);
            chk("write_complete", write_complete, m_wc);
            chk("overflow", overflow, m_ovf);
            chk("frame_err", frame_err, m_ferr);
        end
        if (write_enable === 1'b1) wr_log.push_back(write_data);

        if (!rn) begin
            m_ph = P_IDLE; m_q.delete(); m_cnt = 0; m_wc = 0; m_ovf = 0; m_ferr = 0;
        end else begin
            phase_t nx = m_ph;
            bit     was_empty = (m_q.size() == 0);
            if (e_we) void'(m_q.pop_front());
            case (m_ph)
                P_IDLE: if (v && s) begin
                    m_q.push_back(d);
                    m_cnt = 1;
                    nx = (NPIX == 1) ? P_DRAIN : P_FILL;
                end
                P_FILL: if (v) begin
                    if (s) m_ferr = 1;
                    if (m_q.size() < DEPTH) m_q.push_back(d);
                    else m_ovf = 1;
                    m_cnt++;
                    if (m_cnt == NPIX) nx = P_DRAIN;
                end
                P_DRAIN:   if (was_empty) nx = P_DONE;
                P_DONE:    if (!y) nx = P_RELEASE;
                P_RELEASE: if (y) nx = P_IDLE;
                default:   nx = P_IDLE;
            endcase
            m_ph = nx;
            m_wc = (m_ph == P_DONE);
        end
    endtask

    task automatic idle_cycle(input bit y, input bit r);
        step(1, 0, 0, 8'h00, y, r);
    endtask

    task automatic send_frame(input logic [7:0] base, input int sof_at, input bit r);
        for (int i = 0; i < NPIX; i++)
            step(1, 1, (i == 0) || (i == sof_at), 8'(base + i), 1, r);
    endtask

    // Wait (bounded) for write_complete, then walk the yield handshake back to idle.
    task automatic finish_frame(input string nm);
        int k = 0;
        while (write_complete !== 1'b1 && k < 40) begin
            idle_cycle(1, 1);
            k++;
        end
        chk({nm, "_complete_seen"}, write_complete, 1'b1);
        idle_cycle(0, 1);
        chk({nm, "_complete_held"}, write_complete, 1'b1);
        idle_cycle(0, 1);
        chk({nm, "_complete_dropped"}, write_complete, 1'b0);
        idle_cycle(1, 1);
    endtask

    task automatic check_log(input string nm, input logic [7:0] base, input int n);
        chk({nm, "_write_count"}, wr_log.size(), n);
        for (int i = 0; i < n && i < wr_log.size(); i++)
            chk({nm, "_write_value"}, wr_log[i], 8'(base + i));
        wr_log.delete();
    endtask

    initial begin
        rst_n = 0; pix_valid = 0; pix_sof = 0; pix_data = 0; yield = 1; write_ready = 1;

        // First cycle precedes any reset edge, so outputs are not yet defined.
        step(0, 0, 0, 8'h00, 1, 1);
        en_chk = 1'b1;

        // Vector table: one 8-pixel frame 0x10..0x17 at full rate, then handshake.
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 8'h10, 1, 1, 0, 8'h00, 0, 0, 0));
        for (int i = 1; i < 8; i++)
            tbl.push_back(mk(1, 1, 0, 8'(8'h10 + i), 1, 1, 1, 8'(8'h10 + i - 1), 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 1, 8'h17, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rn, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].y, tbl[i].r);
            chk("tbl_we", write_enable, tbl[i].e_we);
            if (tbl[i].e_we) chk("tbl_data", write_data, tbl[i].e_wd);
            chk("tbl_complete", write_complete, tbl[i].e_wc);
            chk("tbl_overflow", overflow, tbl[i].e_ovf);
            chk("tbl_frame_err", frame_err, tbl[i].e_ferr);
        end
        check_log("frame1", 8'h10, 8);

        // Second frame after the release handshake.
        send_frame(8'h20, -1, 1);
        finish_frame("frame2");
        check_log("frame2", 8'h20, 8);

        // SDRAM stalled for the whole frame: only the first DEPTH pixels survive.
        step(0, 0, 0, 8'h00, 1, 1);
        send_frame(8'h10, -1, 0);
        for (int i = 0; i < 3; i++) idle_cycle(1, 0);
        chk("stall_overflow", overflow, 1'b1);
        chk("stall_no_writes", wr_log.size(), 0);
        finish_frame("stall");
        check_log("stall", 8'h10, DEPTH);

        // Non-SOF pixels while idle are ignored entirely.
        step(0, 0, 0, 8'h00, 1, 1);
        step(1, 1, 0, 8'h55, 1, 1);
        step(1, 1, 0, 8'h66, 1, 1);
        idle_cycle(1, 1);
        idle_cycle(1, 1);
        chk("nosof_no_writes", wr_log.size(), 0);
        chk("nosof_overflow", overflow, 1'b0);
        chk("nosof_frame_err", frame_err, 1'b0);
        send_frame(8'h30, -1, 1);
        finish_frame("after_nosof");
        check_log("after_nosof", 8'h30, 8);

        // SOF repeated on pixel 5: flagged, but frame length unchanged.
        send_frame(8'h40, 4, 1);
        finish_frame("sof_mid");
        chk("sof_mid_frame_err", frame_err, 1'b1);
        check_log("sof_mid", 8'h40, 8);

        // Reset three pixels into a frame, then a clean frame.
        step(0, 0, 0, 8'h00, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, i == 0, 8'(8'h50 + i), 1, 0);
        step(0, 0, 0, 8'h00, 1, 1);
        idle_cycle(1, 1);
        chk("rst_we", write_enable, 1'b0);
        chk("rst_complete", write_complete, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        wr_log.delete();
        send_frame(8'h60, -1, 1);
        finish_frame("after_rst");
        check_log("after_rst", 8'h60, 8);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 499) != 0, ($urandom % 4) != 0, $urandom_range(0, 15) == 0,
                 8'($urandom), $urandom_range(0, 9) != 0, ($urandom % 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
